// File: rtl/riscy_pkg.sv
// Shared types and constants for the riscy fetch/decode front end.
// Holds the default address width, the canonical NOP, opcodes and fetch FSM states.
package riscy_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    BRANCH = 7'b1100011,
    JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, word} entries with flush; head is read combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers words for decode (FETCH_MISALIGN_EN adds misalign trap).
// Latency: request to instr_valid is memory latency + 1; redirect costs one bubble cycle.
// Backpressure: imem_req_ready holds the request stable; stall holds the head; credits keep the buffer from overflowing.
module fetch_unit
  import riscy_pkg::*;
#(
  parameter int               XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  instr_pc,
  output logic [6:0]       op,
  output logic [2:0]       funct3,
  output logic             funct7
`ifdef FETCH_MISALIGN_EN
  ,
  output logic             misalign
`endif
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = XLEN + 32;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  logic [EW-1:0]   head;
  logic [CW1-1:0]  inflight;
  logic            rsp_take, accept, redirect_act;
  logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q, misalign_d;
  logic misaligned;

  assign target       = redirect_pc;
  assign misaligned   = |redirect_pc[1:0];
  assign redirect_act = redirect && (state_q != HALT);
  assign misalign     = misalign_q;
`else
  logic unused_pc_lsb;

  assign target        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign redirect_act  = redirect;
`endif

  // Responses during BOOT belong to a pre-reset request and are ignored.
  assign rsp_take       = imem_rsp_valid && (state_q != BOOT) && (out_q != '0);
  assign inflight       = CW1'(fifo_cnt) + CW1'(out_q);
  assign imem_req_valid = (state_q == RUN) && (inflight < CW1'(FIFO_DEPTH)) && !redirect;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign instr_valid = !fifo_empty && (state_q == RUN);
  assign instr       = fifo_empty ? NOP_INSTR : head[31:0];
  assign instr_pc    = fifo_empty ? pc_q : head[EW-1:32];
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[30];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(rsp_take);
    drop_d     = drop_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
`ifdef FETCH_MISALIGN_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      BOOT, REDIR: state_d = RUN;
      default:     state_d = state_q;
    endcase

    if (redirect_act) begin
      // Everything still in flight, net of this cycle's response, becomes stale.
      fifo_flush = 1'b1;
      pc_d       = target;
      rsp_pc_d   = target;
      drop_d     = out_q - CW'(rsp_take);
      state_d    = REDIR;
`ifdef FETCH_MISALIGN_EN
      if (misaligned) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end
`endif
    end else begin
      if (accept) pc_d = pc_q + XLEN'(4);
      if (rsp_take) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + XLEN'(4);
        end
      end
      fifo_pop = instr_valid && !stall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

  fetch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat ({rsp_pc_q, imem_rsp_data}),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head_dat (head),
    .cnt      (fifo_cnt),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with optional response hold,
// hand-computed expectations checked with immediate assertions.
module tb_fetch_unit;
  import riscy_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
`ifdef FETCH_MISALIGN_EN
  logic        misalign;
`endif

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] pend [$];
  bit          mem_hold;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign       (misalign)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0000_2083;
      32'h4: return 32'h0011_2223;
      32'h8: return 32'h0000_0013;
      default: return {a[11:0], 20'h00013};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request at the falling edge, then answer one cycle after acceptance.
  task automatic tick();
    bit          acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (acc) pend.push_back(a);
    if (!mem_hold && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0; mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'h13);
    chk("rst_instr_pc", 64'(instr_pc), 64'h0);

    rst_n = 1'b1;
    tick();
    chk("boot_req_valid", 64'(imem_req_valid), 64'd1);
    chk("boot_req_addr", 64'(imem_req_addr), 64'h0);
    chk("boot_instr_valid", 64'(instr_valid), 64'd0);
    chk("boot_instr_nop", 64'(instr), 64'h13);
    tick();
    chk("lat_instr_valid", 64'(instr_valid), 64'd0);
    chk("req_addr_4", 64'(imem_req_addr), 64'h4);
    tick();
    chk("lw_valid", 64'(instr_valid), 64'd1);
    chk("lw_pc", 64'(instr_pc), 64'h0);
    chk("lw_instr", 64'(instr), 64'h0000_2083);
    chk("lw_op", 64'(op), 64'(LOAD));
    chk("lw_f3", 64'(funct3), 64'd2);
    chk("lw_f7", 64'(funct7), 64'd0);
    chk("credit_block", 64'(imem_req_valid), 64'd0);
    tick();
    chk("sw_pc", 64'(instr_pc), 64'h4);
    chk("sw_op", 64'(op), 64'(STORE));
    chk("sw_f3", 64'(funct3), 64'd2);
    chk("req_addr_8", 64'(imem_req_addr), 64'h8);
    tick();
    chk("bubble_valid", 64'(instr_valid), 64'd0);
    chk("bubble_nop", 64'(instr), 64'h13);
    chk("req_addr_c", 64'(imem_req_addr), 64'hC);

    imem_req_ready = 1'b0;
    tick();
    chk("addi_pc", 64'(instr_pc), 64'h8);
    chk("addi_op", 64'(op), 64'(OP_IMM));
    chk("addi_f3", 64'(funct3), 64'd0);
    chk("hold_addr_1", 64'(imem_req_addr), 64'hC);
    tick();
    chk("hold_addr_2", 64'(imem_req_addr), 64'hC);
    chk("hold_valid_2", 64'(imem_req_valid), 64'd1);
    tick();
    chk("hold_addr_3", 64'(imem_req_addr), 64'hC);
    imem_req_ready = 1'b1;
    tick();
    chk("accept_adv", 64'(imem_req_addr), 64'h10);

    stall = 1'b1;
    tick();
    chk("stall_head_pc", 64'(instr_pc), 64'hC);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
      chk("stall_instr_pc", 64'(instr_pc), 64'hC);
      chk("stall_instr", 64'(instr), 64'h00C0_0013);
      chk("stall_valid", 64'(instr_valid), 64'd1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", 64'(instr_pc), 64'h10);
    chk("unstall_instr", 64'(instr), 64'h0100_0013);
    chk("unstall_req_addr", 64'(imem_req_addr), 64'h14);

    mem_hold = 1'b1;
    tick();
    chk("out1_req_addr", 64'(imem_req_addr), 64'h18);
    tick();
    chk("out2_req_valid", 64'(imem_req_valid), 64'd0);
    redirect = 1'b1; redirect_pc = 32'h100; mem_hold = 1'b0;
    tick();
    redirect = 1'b0;
    chk("redir_bubble_req", 64'(imem_req_valid), 64'd0);
    chk("redir_bubble_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("redir_req_addr", 64'(imem_req_addr), 64'h100);
    chk("redir_req_valid", 64'(imem_req_valid), 64'd1);
    chk("drop1_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("drop2_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("redir_first_valid", 64'(instr_valid), 64'd1);
    chk("redir_first_pc", 64'(instr_pc), 64'h100);
    chk("redir_first_instr", 64'(instr), 64'h1000_0013);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("redir2_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("redir2_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
    chk("redir2_same_cycle_drop", 64'(instr_valid), 64'd0);
    tick();
    chk("wrap_req_addr", 64'(imem_req_addr), 64'h0);
    tick();
    chk("wrap_top_pc", 64'(instr_pc), 64'hFFFF_FFFC);
    chk("wrap_top_instr", 64'(instr), 64'hFFC0_0013);
    tick();
    chk("wrap_zero_pc", 64'(instr_pc), 64'h0);
    chk("wrap_zero_instr", 64'(instr), 64'h0000_2083);

    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
    chk("mis_flag", 64'(misalign), 64'd1);
    chk("mis_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mis_instr_valid", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
      chk("halt_flag", 64'(misalign), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("mis_reset", 64'(misalign), 64'd0);
`else
    chk("lsb_redir_bubble", 64'(imem_req_valid), 64'd0);
    tick();
    chk("lsb_forced_addr", 64'(imem_req_addr), 64'h100);
    rst_n = 1'b0;
    #1;
`endif
    chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mid_rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'h13);
    chk("mid_rst_pc", 64'(instr_pc), 64'h0);
    pend.delete();
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    chk("boot_stray_ignored", 64'(instr_valid), 64'd0);
    chk("reboot_req_addr", 64'(imem_req_addr), 64'h0);
    chk("reboot_req_valid", 64'(imem_req_valid), 64'd1);
    tick();
    chk("reboot_addr_4", 64'(imem_req_addr), 64'h4);
    tick();
    chk("reboot_first_pc", 64'(instr_pc), 64'h0);
    chk("reboot_first_instr", 64'(instr), 64'h0000_2083);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
